// File: rtl/apb_alu_engine.sv
// APB3 slave around a multi-cycle ALU: registered PREADY (one wait state), byte strobes,
// start/busy/done handshake, shift-add multiplier, PSLVERR on illegal accesses, maskable IRQ.
module apb_alu_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [3:0]  PSTRB,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        IRQ,
  output logic        BUSY
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2} state_t;

  state_t                state_reg, state_next;
  logic [DATA_W-1:0]     a_reg, b_reg;
  logic [3:0]            op_reg;
  logic                  ie_reg;
  logic [31:0]           result_reg;
  logic                  done_reg, err_reg;
  logic [2*DATA_W-1:0]   opa_reg, acc_reg, acc_next;
  logic [DATA_W-1:0]     opb_reg;
  logic [3:0]            lop_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  pready_reg, pslverr_reg;
  logic [31:0]           prdata_reg;

  logic [ADDR_W-3:0]     word;
  logic                  sel_opnd, sel_ctrl, sel_result, sel_status;
  logic                  access, busy, err_cond, wr_ok, start_go, mul_last;
  logic [31:0]           opnd_cur, opnd_new, ctrl_cur, ctrl_new, rd_data, exec_res;
  logic [3:0]            op_new;
  logic [DATA_W:0]       sum_w, diff_w;
  logic                  unused_bits;

  assign word       = PADDR[ADDR_W-1:2];
  assign sel_opnd   = (word == (ADDR_W-2)'(0));
  assign sel_ctrl   = (word == (ADDR_W-2)'(1));
  assign sel_result = (word == (ADDR_W-2)'(2));
  assign sel_status = (word == (ADDR_W-2)'(3));

  // Access phase is acted on only once; the registered PREADY masks the second cycle.
  assign access   = PSEL & PENABLE & ~pready_reg;
  assign busy     = (state_reg != IDLE);
  assign err_cond = (PADDR[1:0] != 2'b00) | (PWRITE & sel_result) |
                    (PWRITE & busy & (sel_opnd | sel_ctrl));
  assign wr_ok    = access & PWRITE & ~err_cond;
  assign start_go = wr_ok & sel_ctrl & PSTRB[1] & PWDATA[8];
  assign op_new   = ctrl_new[3:0];
  assign mul_last = (cnt_reg == CNT_W'(DATA_W - 1));

  always_comb begin
    opnd_cur = '0;
    opnd_cur[DATA_W-1:0]  = a_reg;
    opnd_cur[16+:DATA_W]  = b_reg;
  end
  assign ctrl_cur = {27'b0, ie_reg, op_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign opnd_new[8*gi+:8] = PSTRB[gi] ? PWDATA[8*gi+:8] : opnd_cur[8*gi+:8];
      assign ctrl_new[8*gi+:8] = PSTRB[gi] ? PWDATA[8*gi+:8] : ctrl_cur[8*gi+:8];
    end
  endgenerate

  always_comb begin
    sum_w  = {1'b0, opa_reg[DATA_W-1:0]} + {1'b0, opb_reg};
    diff_w = {1'b0, opa_reg[DATA_W-1:0]} - {1'b0, opb_reg};
    case (lop_reg)
      4'd0:    exec_res = 32'(sum_w);
      4'd1:    exec_res = 32'(diff_w);
      4'd2:    exec_res = 32'(opa_reg[DATA_W-1:0] & opb_reg);
      4'd3:    exec_res = 32'(opa_reg[DATA_W-1:0] | opb_reg);
      4'd4:    exec_res = 32'(opa_reg[DATA_W-1:0] ^ opb_reg);
      default: exec_res = 32'b0;
    endcase
  end

  // Multiplicand shifts left and multiplier shifts right, so bit 0 always selects the addend.
  assign acc_next = acc_reg + (opb_reg[0] ? opa_reg : '0);

  always_comb begin
    rd_data = 32'b0;
    if (sel_opnd)   rd_data = opnd_cur;
    if (sel_ctrl)   rd_data = ctrl_cur;
    if (sel_result) rd_data = result_reg;
    if (sel_status) rd_data = {29'b0, err_reg, done_reg, busy};
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start_go && op_new <= 4'd5) state_next = (op_new == 4'd5) ? MUL : EXEC;
      EXEC: state_next = IDLE;
      MUL:  if (mul_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      ie_reg      <= 1'b0;
      result_reg  <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      opa_reg     <= '0;
      opb_reg     <= '0;
      acc_reg     <= '0;
      lop_reg     <= '0;
      cnt_reg     <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      prdata_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      pready_reg  <= access;
      pslverr_reg <= access & err_cond;
      if (access && !PWRITE && !err_cond) prdata_reg <= rd_data;
      if (wr_ok && sel_opnd) begin
        a_reg <= opnd_new[DATA_W-1:0];
        b_reg <= opnd_new[16+:DATA_W];
      end
      if (wr_ok && sel_ctrl) begin
        op_reg <= ctrl_new[3:0];
        ie_reg <= ctrl_new[4];
      end
      if (wr_ok && sel_status && PWDATA[1]) begin
        done_reg <= 1'b0;
        err_reg  <= 1'b0;
      end
      if (start_go) begin
        opa_reg  <= (2*DATA_W)'(a_reg);
        opb_reg  <= b_reg;
        lop_reg  <= op_new;
        acc_reg  <= '0;
        cnt_reg  <= '0;
        done_reg <= 1'b0;
        err_reg  <= 1'b0;
        if (op_new > 4'd5) begin
          done_reg   <= 1'b1;
          err_reg    <= 1'b1;
          result_reg <= '0;
        end
      end
      // Completion is assigned last so it overrides a same-edge W1C of DONE.
      case (state_reg)
        EXEC: begin
          result_reg <= exec_res;
          done_reg   <= 1'b1;
        end
        MUL: begin
          acc_reg <= acc_next;
          opa_reg <= opa_reg << 1;
          opb_reg <= opb_reg >> 1;
          cnt_reg <= cnt_reg + 1'b1;
          if (mul_last) begin
            result_reg <= 32'(acc_next);
            done_reg   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign PRDATA  = prdata_reg;
  assign PREADY  = pready_reg;
  assign PSLVERR = pslverr_reg;
  assign BUSY    = busy;
  assign IRQ     = done_reg & ie_reg;

  assign unused_bits = ^{PADDR[31:ADDR_W], opnd_new, ctrl_new[31:5]};

endmodule

// File: tb/tb_apb_alu_engine.sv
// Directed plus randomized bench for apb_alu_engine; randomized ops are scored against
// a plain-arithmetic reference model.
module tb_apb_alu_engine;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic        PCLK, PRESETn, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR, IRQ, BUSY;

  apb_alu_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .IRQ(IRQ), .BUSY(BUSY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, output logic [31:0] rdata, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
    tick();
    PENABLE = 1'b1;
    check("wait_state", {31'b0, PREADY}, 32'd0);
    tick();
    check("pready", {31'b0, PREADY}, 32'd1);
    rdata = PRDATA;
    err   = PSLVERR;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    $display("apb %s addr=%h wdata=%h strb=%b rdata=%h slverr=%b",
             wr ? "WR" : "RD", addr, data, strb, rdata, err);
  endtask

  // Counts cycles BUSY is seen high, starting from the sample right after the START edge.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (BUSY === 1'b1 && cycles < 200) begin
      cycles++;
      tick();
    end
    if (cycles >= 200) check("busy_timeout", {31'b0, BUSY}, 32'd0);
  endtask

  function automatic logic [31:0] ref_alu(input int op, input longint a, input longint b);
    longint r;
    case (op)
      0: r = a + b;
      1: r = (a - b) & ((longint'(1) << (DATA_W + 1)) - 1);
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a * b;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          cyc;
    logic [31:0] m_result;
    logic        m_done, m_err;

    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    tick(); tick();
    check("rst_pready", {31'b0, PREADY}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_busy_irq", {30'b0, BUSY, IRQ}, 32'd0);
    PRESETn = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      apb(1'b0, 32'(4 * i), 32'h0, 4'hF, d, e);
      check("rst_map_data", d, 32'd0);
      check("rst_map_err", {31'b0, e}, 32'd0);
    end

    // ADD with carry out
    apb(1'b1, 32'h0, 32'h0001FFFF, 4'hF, d, e);
    apb(1'b1, 32'h4, 32'h00000100, 4'hF, d, e);
    wait_idle(cyc);
    check("add_busy_cycles", 32'(cyc), 32'd1);
    apb(1'b0, 32'h8, 32'h0, 4'hF, d, e);
    check("add_result", d, 32'h00010000);
    apb(1'b0, 32'hC, 32'h0, 4'hF, d, e);
    check("add_status", d, 32'h2);

    // SUB with borrow, started without clearing DONE
    apb(1'b1, 32'h0, 32'h00050003, 4'hF, d, e);
    apb(1'b1, 32'h4, 32'h00000101, 4'hF, d, e);
    wait_idle(cyc);
    apb(1'b0, 32'h8, 32'h0, 4'hF, d, e);
    check("sub_result", d, 32'h0001FFFE);

    // MUL with interrupt
    apb(1'b1, 32'h0, 32'hFFFFFFFF, 4'hF, d, e);
    apb(1'b1, 32'h4, 32'h00000115, 4'hF, d, e);
    wait_idle(cyc);
    check("mul_busy_cycles", 32'(cyc), 32'(DATA_W));
    apb(1'b0, 32'h8, 32'h0, 4'hF, d, e);
    check("mul_result", d, 32'hFFFE0001);
    check("mul_irq", {31'b0, IRQ}, 32'd1);
    apb(1'b1, 32'hC, 32'h2, 4'hF, d, e);
    check("w1c_irq", {31'b0, IRQ}, 32'd0);
    apb(1'b0, 32'hC, 32'h0, 4'hF, d, e);
    check("w1c_status", d, 32'h0);

    // Error responses
    apb(1'b1, 32'h8, 32'h12345678, 4'hF, d, e);
    check("wr_result_err", {31'b0, e}, 32'd1);
    apb(1'b0, 32'h8, 32'h0, 4'hF, d, e);
    check("wr_result_kept", d, 32'hFFFE0001);
    apb(1'b1, 32'h4, 32'h00000115, 4'hF, d, e);
    apb(1'b1, 32'h0, 32'h12345678, 4'hF, d, e);
    check("busy_opnd_err", {31'b0, e}, 32'd1);
    apb(1'b1, 32'h4, 32'h00000100, 4'hF, d, e);
    check("busy_ctrl_err", {31'b0, e}, 32'd1);
    apb(1'b0, 32'hC, 32'h0, 4'hF, d, e);
    check("busy_read_status", d, 32'h1);
    check("busy_read_err", {31'b0, e}, 32'd0);
    wait_idle(cyc);
    apb(1'b0, 32'h0, 32'h0, 4'hF, d, e);
    check("busy_opnd_kept", d, 32'hFFFFFFFF);
    apb(1'b0, 32'h4, 32'h0, 4'hF, d, e);
    check("ctrl_readback", d, 32'h15);
    apb(1'b0, 32'h2, 32'h0, 4'hF, d, e);
    check("misaligned_err", {31'b0, e}, 32'd1);

    // Illegal opcode
    apb(1'b1, 32'h4, 32'h00000109, 4'hF, d, e);
    wait_idle(cyc);
    check("badop_busy_cycles", 32'(cyc), 32'd0);
    apb(1'b0, 32'hC, 32'h0, 4'hF, d, e);
    check("badop_status", d, 32'h6);
    apb(1'b0, 32'h8, 32'h0, 4'hF, d, e);
    check("badop_result", d, 32'h0);

    // Byte strobes
    apb(1'b1, 32'h0, 32'h0, 4'hF, d, e);
    apb(1'b1, 32'h0, 32'hAABBCCDD, 4'b0001, d, e);
    apb(1'b0, 32'h0, 32'h0, 4'hF, d, e);
    check("strb_lane0", d, 32'h000000DD);
    apb(1'b1, 32'h0, 32'hFFFFFFFF, 4'b0000, d, e);
    check("strb_none_err", {31'b0, e}, 32'd0);
    apb(1'b1, 32'h0, 32'h00110000, 4'b0100, d, e);
    apb(1'b0, 32'h0, 32'h0, 4'hF, d, e);
    check("strb_lane2", d, 32'h001100DD);

    // W1C landing on the completion edge: completion wins
    apb(1'b1, 32'h4, 32'h00000105, 4'hF, d, e);
    for (int i = 0; i < DATA_W - 2; i++) tick();
    apb(1'b1, 32'hC, 32'h2, 4'hF, d, e);
    apb(1'b0, 32'hC, 32'h0, 4'hF, d, e);
    check("w1c_collision_status", d, 32'h2);
    apb(1'b0, 32'h8, 32'h0, 4'hF, d, e);
    check("collision_result", d, 32'(32'hDD * 32'h11));

    // Reset in the middle of a multiply
    apb(1'b1, 32'h4, 32'h00000115, 4'hF, d, e);
    for (int i = 0; i < 6; i++) tick();
    check("pre_reset_busy", {31'b0, BUSY}, 32'd1);
    PRESETn = 1'b0;
    #1;
    check("async_reset_busy", {31'b0, BUSY}, 32'd0);
    check("async_reset_irq", {31'b0, IRQ}, 32'd0);
    tick();
    PRESETn = 1'b1;
    tick();
    apb(1'b0, 32'h8, 32'h0, 4'hF, d, e);
    check("reset_result", d, 32'h0);
    apb(1'b0, 32'hC, 32'h0, 4'hF, d, e);
    check("reset_status", d, 32'h0);
    apb(1'b0, 32'h0, 32'h0, 4'hF, d, e);
    check("reset_opnd", d, 32'h0);

    // Randomized operations against the reference model
    m_result = 32'h0; m_done = 1'b0; m_err = 1'b0;
    for (int it = 0; it < 40; it++) begin
      int a, b, op, ie, exp_cyc;
      a  = int'($urandom_range(0, (1 << DATA_W) - 1));
      b  = int'($urandom_range(0, (1 << DATA_W) - 1));
      op = int'($urandom_range(0, 9));
      ie = int'($urandom_range(0, 1));
      apb(1'b1, 32'h0, (32'(b) << 16) | 32'(a), 4'hF, d, e);
      apb(1'b1, 32'h4, 32'h100 | (32'(ie) << 4) | 32'(op), 4'hF, d, e);
      wait_idle(cyc);
      exp_cyc  = (op < 5) ? 1 : (op == 5) ? DATA_W : 0;
      m_result = ref_alu(op, longint'(a), longint'(b));
      m_done   = 1'b1;
      m_err    = (op > 5);
      check("rnd_busy_cycles", 32'(cyc), 32'(exp_cyc));
      apb(1'b0, 32'h8, 32'h0, 4'hF, d, e);
      check("rnd_result", d, m_result);
      apb(1'b0, 32'hC, 32'h0, 4'hF, d, e);
      check("rnd_status", d, {29'b0, m_err, m_done, 1'b0});
      check("rnd_irq", {31'b0, IRQ}, {31'b0, m_done & ie[0]});
      if ($urandom_range(0, 1) == 1) begin
        apb(1'b1, 32'hC, 32'h2, 4'hF, d, e);
        m_done = 1'b0; m_err = 1'b0;
        apb(1'b0, 32'hC, 32'h0, 4'hF, d, e);
        check("rnd_clear_status", d, {29'b0, m_err, m_done, 1'b0});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/apb_alu_engine.md
Name: apb_alu_engine

Overview:
- Parametrised APB3 slave wrapping a multi-cycle ALU, successor to the single-cycle APB ALU slave.
- Adds configurable operand width, a start/busy/done handshake, an iterative multiplier, PSLVERR on illegal accesses and a maskable interrupt.
- Sits on the peripheral APB bus behind the PCIe APB master.

Parameters:
- DATA_W, 16, operand width in bits; legal range 4..16, so a 2*DATA_W product fits in 32 bits.
- ADDR_W, 4, number of PADDR bits decoded; PADDR bits above ADDR_W are ignored.

Ports:
- PCLK  in  1  APB clock.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  32  byte address; word-aligned only.
- PSTRB  in  4  byte write strobes.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response, valid while PREADY=1.
- IRQ  out  1  level interrupt, equals DONE & IE.
- BUSY  out  1  ALU executing.

Behaviour:
- Reset (asynchronous): all registers 0; FSM in IDLE; PRDATA=0, PREADY=0, PSLVERR=0, IRQ=0, BUSY=0.
- Register map (byte offset):
  - 0x0 OPND: A=[DATA_W-1:0], B=[16+DATA_W-1:16]; R/W; other bits read 0.
  - 0x4 CTRL: OP=[3:0], IE=[4]; START=[8] is write-1-to-start and always reads 0.
  - 0x8 RESULT: read-only, zero-extended.
  - 0xC STATUS: BUSY=[0], DONE=[1], ERR=[2]; read-only except writing 1 to bit1 clears both DONE and ERR.
- APB timing:
  - PREADY is registered, so every transfer has exactly one wait state.
  - PREADY rises the cycle after PSEL&PENABLE is first seen and stays high for one cycle.
  - The write commits, or PRDATA is loaded, on the edge that raises PREADY.
  - PREADY returns to 0 whenever PSEL&PENABLE is low.
- Byte strobes: honoured on OPND and CTRL only; a byte lane updates only when its PSTRB bit is 1. PSTRB=0 is a legal no-op write.
- PSLVERR=1, with no state change, for any of these:
  - PADDR[1:0] != 0;
  - write to RESULT;
  - write to OPND or CTRL while BUSY=1.
  - A read while BUSY returns the current values; no error.
- FSM states:
  - IDLE: a CTRL write with START=1 (byte lane 1 strobed) latches A, B and OP, sets BUSY, clears DONE and ERR, then moves to EXEC or MUL.
    - OP in {0,1,2,3,4}: go to EXEC.
    - OP == 5: go to MUL.
    - Any other OP: ERR=1, DONE=1, RESULT=0, BUSY=0; stay in IDLE.
  - EXEC: one cycle. RESULT is written, BUSY=0, DONE=1, then back to IDLE.
  - MUL: shift-add, one multiplier bit per cycle, counter 0..DATA_W-1. When the count reaches DATA_W-1, RESULT is written and the FSM moves to IDLE with DONE=1.
- Latency, counted from the START write edge T:
  - EXEC ops: DONE=1 after T+1.
  - MUL: DONE=1 after T+DATA_W.
  - BUSY is high for exactly 1 cycle (EXEC ops) or DATA_W cycles (MUL).
- Arithmetic:
  - OP0 ADD: A+B, DATA_W+1 bits; carry in bit DATA_W.
  - OP1 SUB: A-B modulo 2^(DATA_W+1); bit DATA_W=1 means borrow (A<B).
  - OP2 AND, OP3 OR, OP4 XOR: DATA_W bits.
  - OP5 MUL: unsigned, 2*DATA_W bits.
- Simultaneous events:
  - A STATUS W1C landing on the same edge that completion sets DONE: completion wins and DONE stays 1.
  - START with OP=5 and IE=1 written together: IE takes effect immediately.
- Reset asserted mid-operation: the operation is aborted and all registers return to their reset values; there is no partial RESULT.
- Back-to-back starts: a new START is accepted as soon as BUSY=0; DONE does not need to be cleared first.

Test Plan:
- Reset and map: after reset, read 0x0/0x4/0x8/0xC -> all return 0x00000000, each with PREADY after one wait state and PSLVERR=0.
- ADD carry: OPND=0x0001FFFF, CTRL=0x00000100 -> BUSY high 1 cycle, RESULT=0x00010000, STATUS=0x2.
- SUB borrow: OPND=0x00050003 (A=3, B=5), OP=1 plus START -> RESULT=0x0001FFFE.
- MUL with IRQ: OPND=0xFFFFFFFF, CTRL=0x115 -> BUSY high exactly 16 cycles, RESULT=0xFFFE0001, IRQ=1. Write 0x2 to 0xC -> IRQ=0 and STATUS=0.
- Errors:
  - Write to 0x8 -> PSLVERR=1, RESULT unchanged.
  - OPND write during MUL -> PSLVERR=1, OPND unchanged.
  - PADDR=0x2 -> PSLVERR=1.
  - OP=0x9 plus START -> STATUS=0x6, RESULT=0.
- Strobes and reset: PSTRB=0001, PWDATA=0xAABBCCDD to OPND holding 0 -> OPND=0x000000DD. Assert PRESETn low at MUL cycle 7 -> BUSY=0, RESULT=0, STATUS=0.
